// File: rtl/register_file_writeback.sv
// Write end of the SimpleRISC register file: 16 x 32-bit array with a one-deep commit stage,
// a post-reset clear sweep, and two combinational read ports with write-through bypass.
module register_file_writeback #(
   parameter int unsigned NREGS   = 16,
   parameter int unsigned RA_IDX  = 15,
   parameter int unsigned SP_IDX  = 14,
   parameter logic [31:0] SP_INIT = 32'h0000_0FFC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] inst,
   input  logic [31:0] pc,
   input  logic [31:0] alu_result,
   input  logic [31:0] ld_result,
   input  logic        is_wb,
   input  logic        is_ld,
   input  logic        is_call,
   input  logic [3:0]  rd_addr1,
   input  logic [3:0]  rd_addr2,
   output logic [31:0] rd_data1,
   output logic [31:0] rd_data2,
   output logic        wb_valid,
   output logic [3:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        init_done
);

   localparam logic [3:0] RaAddr = 4'(RA_IDX);
   localparam logic [3:0] SpAddr = 4'(SP_IDX);

   typedef enum logic [0:0] {StClear, StRun} state_e;

   state_e      state_q;
   logic [3:0]  clr_cnt_q;
   logic [31:0] regs_q [NREGS];

   logic        accept;
   logic [3:0]  cap_addr;
   logic [31:0] cap_data;
   logic        unused_inst;

   assign accept      = in_valid & in_ready;
   assign unused_inst = ^{inst[31:26], inst[21:0]};

   // Call overrides both the load select and the encoded destination.
   always_comb begin
      cap_addr = inst[25:22];
      cap_data = is_ld ? ld_result : alu_result;
      if (is_call) begin
         cap_addr = RaAddr;
         cap_data = pc + 32'd4;
      end
   end

   // Control FSM plus the commit stage; wb_addr/wb_data double as the staged destination/data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StClear;
         clr_cnt_q <= 4'd0;
         in_ready  <= 1'b0;
         init_done <= 1'b0;
         wb_valid  <= 1'b0;
         wb_addr   <= 4'd0;
         wb_data   <= 32'd0;
      end else begin
         unique case (state_q)
            StClear: begin
               clr_cnt_q <= clr_cnt_q + 4'd1;
               if (clr_cnt_q == 4'd15) begin
                  state_q   <= StRun;
                  in_ready  <= 1'b1;
                  init_done <= 1'b1;
               end
            end
            StRun: begin
               in_ready  <= 1'b1;
               init_done <= 1'b1;
            end
            default: state_q <= StClear;
         endcase
         wb_valid <= accept & (is_wb | is_call);
         if (accept) begin
            wb_addr <= cap_addr;
            wb_data <= cap_data;
         end
      end
   end

   // The array has no reset of its own; the sweep initialises it and a reset drops the commit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == StClear) begin
            regs_q[clr_cnt_q] <= (clr_cnt_q == SpAddr) ? SP_INIT : 32'd0;
         end else if (wb_valid) begin
            regs_q[wb_addr] <= wb_data;
         end
      end
   end

   assign rd_data1 = (wb_valid && (wb_addr == rd_addr1)) ? wb_data : regs_q[rd_addr1];
   assign rd_data2 = (wb_valid && (wb_addr == rd_addr2)) ? wb_data : regs_q[rd_addr2];

endmodule

// File: tb/tb_register_file_writeback.sv
// Randomised scoreboard bench for register_file_writeback: an architectural register model
// predicts commits and read-port values; a negedge monitor compares against the DUT.
module tb_register_file_writeback;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] inst = '0;
   logic [31:0] pc = '0;
   logic [31:0] alu_result = '0;
   logic [31:0] ld_result = '0;
   logic        is_wb = 1'b0;
   logic        is_ld = 1'b0;
   logic        is_call = 1'b0;
   logic [3:0]  rd_addr1 = '0;
   logic [3:0]  rd_addr2 = '0;
   logic [31:0] rd_data1;
   logic [31:0] rd_data2;
   logic        wb_valid;
   logic [3:0]  wb_addr;
   logic [31:0] wb_data;
   logic        init_done;

   register_file_writeback dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .inst       (inst),
      .pc         (pc),
      .alu_result (alu_result),
      .ld_result  (ld_result),
      .is_wb      (is_wb),
      .is_ld      (is_ld),
      .is_call    (is_call),
      .rd_addr1   (rd_addr1),
      .rd_addr2   (rd_addr2),
      .rd_data1   (rd_data1),
      .rd_data2   (rd_data2),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .init_done  (init_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  addr;
      logic [31:0] data;
   } commit_t;

   commit_t     sb[$];
   logic [31:0] model [16];
   bit          run = 1'b0;
   bit          mon_en = 1'b0;
   bit          pend = 1'b0;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: decoupled from stimulus, compares whatever the DUT presents each cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         check("wb_valid", {31'd0, wb_valid}, {31'd0, pend});
         if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
               check("commit_unexpected", 32'd1, 32'd0);
            end else begin
               commit_t e;
               e = sb.pop_front();
               check("wb_addr", {28'd0, wb_addr}, {28'd0, e.addr});
               check("wb_data", wb_data, e.data);
            end
         end
         if (run) begin
            check("rd_data1", rd_data1, model[rd_addr1]);
            check("rd_data2", rd_data2, model[rd_addr2]);
         end
      end
   end

   function automatic void model_clear();
      for (int i = 0; i < 16; i++) model[i] = (i == 14) ? 32'h0000_0FFC : 32'd0;
   endfunction

   // Reset, then verify the 16-cycle sweep window on in_ready/init_done.
   task automatic reset_and_sweep();
      rst = 1'b1;
      @(posedge clk);
      model_clear();
      pend   = 1'b0;
      run    = 1'b0;
      mon_en = 1'b1;
      sb.delete();
      #1 rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("in_ready_clear", {31'd0, in_ready}, 32'd0);
         check("init_done_clear", {31'd0, init_done}, 32'd0);
      end
      @(negedge clk);
      check("in_ready_run", {31'd0, in_ready}, 32'd1);
      check("init_done_run", {31'd0, init_done}, 32'd1);
      run = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit v, input bit wb, input bit ld, input bit call,
                        input logic [3:0] rd, input logic [31:0] pcv, input logic [31:0] alu,
                        input logic [31:0] ldv, input logic [3:0] a1, input logic [3:0] a2);
      bit          acc;
      logic [3:0]  ea;
      logic [31:0] ed;
      in_valid    = v;
      is_wb       = wb;
      is_ld       = ld;
      is_call     = call;
      inst        = $urandom;
      inst[25:22] = rd;
      pc          = pcv;
      alu_result  = alu;
      ld_result   = ldv;
      rd_addr1    = a1;
      rd_addr2    = a2;
      acc = v && run;
      @(posedge clk);
      if (acc && (wb || call)) begin
         ea = call ? 4'd15 : rd;
         ed = call ? pcv + 32'd4 : (ld ? ldv : alu);
         model[ea] = ed;
         sb.push_back('{addr: ea, data: ed});
      end
      pend = acc && (wb || call);
      #1 in_valid = 1'b0;
   endtask

   task automatic idle(input logic [3:0] a1, input logic [3:0] a2);
      issue(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd0, a1, a2);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(posedge clk);
      #1;
      reset_and_sweep();
      // Sweep results: r14 = SP_INIT, everything else zero.
      for (int i = 0; i < 16; i += 2) idle(4'(i), 4'(i + 1));

      issue(1, 1, 0, 0, 4'd3, 32'h0, 32'hDEAD_BEEF, 32'h1234_5678, 4'd0, 4'd3);
      idle(4'd3, 4'd0);
      idle(4'd3, 4'd3);

      issue(1, 0, 1, 1, 4'd2, 32'h0000_0100, 32'h5555_5555, 32'hAAAA_AAAA, 4'd15, 4'd2);
      idle(4'd15, 4'd2);
      issue(1, 1, 0, 1, 4'd4, 32'hFFFF_FFFC, 32'h5555_5555, 32'hAAAA_AAAA, 4'd15, 4'd4);
      idle(4'd15, 4'd4);

      issue(1, 1, 0, 0, 4'd5, 32'h0, 32'h1111_1111, 32'h0, 4'd0, 4'd5);
      issue(1, 1, 0, 0, 4'd5, 32'h0, 32'h2222_2222, 32'h0, 4'd0, 4'd5);
      idle(4'd5, 4'd5);
      idle(4'd5, 4'd5);

      issue(1, 0, 0, 0, 4'd7, 32'h0, 32'h7777_7777, 32'h0, 4'd7, 4'd7);
      idle(4'd7, 4'd7);

      // r0 is an ordinary register.
      issue(1, 1, 1, 0, 4'd0, 32'h0, 32'h0, 32'h0BAD_F00D, 4'd0, 4'd0);
      idle(4'd0, 4'd0);

      for (int i = 0; i < 400; i++) begin
         logic [31:0] pcv;
         pcv = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom;
         issue(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 1)), bit'($urandom_range(0, 5) == 0),
               4'($urandom_range(0, 15)), pcv, $urandom, $urandom,
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      idle(4'd9, 4'd14);

      // Reset right behind an accepted write: it must never land.
      issue(1, 1, 0, 0, 4'd9, 32'h0, 32'hCAFE_0001, 32'h0, 4'd9, 4'd0);
      reset_and_sweep();
      idle(4'd9, 4'd14);
      idle(4'd9, 4'd15);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_file_writeback.md
Name: register_file_writeback

Overview:
- Write end of the SimpleRISC register file: owns the 16 x 32-bit register array and commits results from the memory-access stage into it.
- Sits between the MA stage (upstream, valid/ready handshake) and the operand-fetch logic, which reads through two combinational read ports with write-through bypass.
- After reset, a sweep FSM clears the array before the block accepts any instruction.

Parameters:
- NREGS, 16, number of architectural registers (address width fixed at 4).
- RA_IDX, 15, register written by call.
- SP_IDX, 14, stack pointer register.
- SP_INIT, 32'h0000_0FFC, value loaded into SP_IDX during the clear sweep.

Ports:
- clk  in  1  single clock, all state rises on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  MA stage presents a retiring instruction
- in_ready  out  1  block can accept this cycle
- inst  in  32  instruction word; rd = inst[25:22]
- pc  in  32  PC of the instruction
- alu_result  in  32  ALU output
- ld_result  in  32  load data
- is_wb  in  1  instruction writes a register
- is_ld  in  1  select ld_result
- is_call  in  1  write pc+4 to RA_IDX
- rd_addr1, rd_addr2  in  4  read-port addresses
- rd_data1, rd_data2  out  32  read data (bypassed)
- wb_valid  out  1  commit happens on the next edge
- wb_addr  out  4  commit destination
- wb_data  out  32  commit data
- init_done  out  1  clear sweep finished

Behaviour:
- Reset (rst=1 at posedge):
  - state=CLEAR, clr_cnt=0, stage_valid=0.
  - Outputs: in_ready=0, wb_valid=0, wb_addr=0, wb_data=0, init_done=0.
  - Any pending commit is discarded.
- FSM CLEAR:
  - Each cycle writes regs[clr_cnt] = (clr_cnt==SP_IDX) ? SP_INIT : 0, then increments clr_cnt.
  - When clr_cnt==15 is written, the next state is RUN; the sweep takes 16 cycles.
  - in_ready=0 throughout; in_valid is ignored.
- FSM RUN:
  - init_done=1 and in_ready=1.
  - The stage never back-pressures, because the commit always completes in one cycle.
- Capture (RUN, in_valid & in_ready at edge N):
  - stage_valid <= 1.
  - stage_we <= is_wb | is_call.
  - stage_addr <= is_call ? RA_IDX : inst[25:22].
  - stage_data <= is_call ? pc+32'd4 : (is_ld ? ld_result : alu_result).
  - If no capture occurs, stage_valid <= 0.
- Priority: is_call overrides is_ld and rd. pc+4 wraps modulo 2^32 (pc=FFFF_FFFC gives 0).
- Commit (edge N+1): if stage_valid & stage_we, regs[stage_addr] <= stage_data.
  - Latency from accept to architectural update is 2 edges.
  - Back-to-back accepts sustain 1 instruction/cycle.
- Commit observation outputs:
  - wb_valid = stage_valid & stage_we.
  - wb_addr and wb_data mirror stage_addr and stage_data. They are registered and hold their last value when wb_valid=0.
- Read ports (combinational):
  - rd_dataX = (wb_valid & wb_addr==rd_addrX) ? wb_data : regs[rd_addrX].
  - The bypass applies to every register, including r0; SimpleRISC r0 is not hardwired.
- Reads in CLEAR state return the array contents; they are undefined until init_done=1.
- Same-address consecutive writes: the later one wins. The bypass always shows the pending (newest) value.
- rst asserted mid-stream: the in-flight stage is dropped (its write does not occur) and the sweep restarts from clr_cnt=0.

Test Plan:
- Reset, then idle 16 cycles -> init_done rises on cycle 17; reading r14 gives 0000_0FFC; r0..r13 and r15 give 0; in_ready=0 until then.
- Accept is_wb=1, inst[25:22]=3, alu_result=DEAD_BEEF -> wb_valid=1, wb_addr=3 next cycle; rd_addr1=3 returns DEAD_BEEF via bypass that cycle and from the array afterward.
- is_call=1, is_ld=1, pc=0000_0100 -> r15=0000_0104; ld_result is ignored. Repeat with pc=FFFF_FFFC -> r15=0.
- Back-to-back writes to r5 (11111111, then 22222222) -> rd_data2 shows 11111111, then 22222222; final r5=22222222.
- is_wb=0 instruction with rd=7 -> wb_valid stays 0 and r7 is unchanged.
- Accept a write to r9=CAFE_0001, assert rst on the next edge -> r9 is never written (clears to 0); init_done=0 for 16 cycles, then 1.
